// File: rtl/image_fuser_pipe_pkg.sv
// Shared mode encodings and width helpers for the image fuser pipeline.
package image_fuser_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_COLOR   = 2'd0,
        MODE_OVERLAY = 2'd1,
        MODE_BLEND   = 2'd2,
        MODE_EDGE    = 2'd3
    } mode_t;

    function automatic int pix_width(input int ch_w, input int num_ch);
        return ch_w * num_ch;
    endfunction

    // Wide enough to hold the sum of num_ch full-scale channels.
    function automatic int sum_width(input int ch_w, input int num_ch);
        return ch_w + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/image_fuser_pipe_blend_ch.sv
// Single-channel alpha blend: (e*a + c*(2^CH_W - a)) >> CH_W, combinational.
module fuser_blend_ch #(
    parameter int CH_W = 8
) (
    input  logic [CH_W-1:0] edge_ch,
    input  logic [CH_W-1:0] color_ch,
    input  logic [CH_W:0]   alpha,
    output logic [CH_W-1:0] blend_ch
);
    localparam int PROD_W = 2 * CH_W + 1;
    localparam logic [CH_W:0] ALPHA_ONE = {1'b1, {CH_W{1'b0}}};

    logic [CH_W:0]   alpha_inv;
    logic [PROD_W-1:0] acc;

    assign alpha_inv = ALPHA_ONE - alpha;
    // Endpoints a=0 and a=2^CH_W reduce exactly to c and e after the shift.
    assign acc       = PROD_W'(edge_ch) * PROD_W'(alpha) + PROD_W'(color_ch) * PROD_W'(alpha_inv);
    assign blend_ch  = CH_W'(acc >> CH_W);

endmodule

// File: rtl/image_fuser_pipe.sv
// Fuses edge and colour pixel streams per frame mode; 3-cycle latency.
// Whole pipeline stalls while out_valid is high and out_ready is low.
module image_fuser_pipe
    import image_fuser_pipe_pkg::*;
#(
    parameter int CH_W   = 8,
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 20,
    parameter logic [CH_W*NUM_CH-1:0] OVL_COLOR = '0,
    localparam int PIX_W = pix_width(CH_W, NUM_CH),
    localparam int SUM_W = sum_width(CH_W, NUM_CH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PIX_W-1:0] edge_pix,
    input  logic [PIX_W-1:0] color_pix,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [CH_W:0]    alpha,
    input  logic [SUM_W-1:0] threshold,
    output logic [PIX_W-1:0] fused_pix,
    output logic             out_valid,
    output logic             out_sof,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pix_cnt,
    output logic [CNT_W-1:0] edge_cnt
);
    localparam logic [CH_W:0] ALPHA_MAX = {1'b1, {CH_W{1'b0}}};

    logic adv, in_xfer, out_xfer;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign in_xfer  = in_valid && adv;
    assign out_xfer = out_valid && out_ready;

    logic [CH_W:0]    alpha_clamp;
    logic [SUM_W-1:0] in_sum;
    assign alpha_clamp = (alpha > ALPHA_MAX) ? ALPHA_MAX : alpha;

    always_comb begin
        in_sum = '0;
        for (int i = 0; i < NUM_CH; i++)
            in_sum = in_sum + SUM_W'(edge_pix[i*CH_W +: CH_W]);
    end

    // A sof pixel uses the live config directly, so the frame's settings travel
    // with its pixels and never leak onto older pixels still in flight.
    mode_t            sh_mode, cfg_mode;
    logic [CH_W:0]    sh_alpha, cfg_alpha;
    logic [SUM_W-1:0] sh_thr, cfg_thr;
    assign cfg_mode  = in_sof ? mode_t'(mode) : sh_mode;
    assign cfg_alpha = in_sof ? alpha_clamp : sh_alpha;
    assign cfg_thr   = in_sof ? threshold : sh_thr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_mode  <= MODE_COLOR;
            sh_alpha <= '0;
            sh_thr   <= '0;
        end else if (in_xfer && in_sof) begin
            sh_mode  <= mode_t'(mode);
            sh_alpha <= alpha_clamp;
            sh_thr   <= threshold;
        end
    end

    logic             s1_vld, s1_sof;
    logic [PIX_W-1:0] s1_edge, s1_color;
    logic [SUM_W-1:0] s1_sum, s1_thr;
    logic [CH_W:0]    s1_alpha;
    mode_t            s1_mode;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld   <= 1'b0;
            s1_sof   <= 1'b0;
            s1_edge  <= '0;
            s1_color <= '0;
            s1_sum   <= '0;
            s1_thr   <= '0;
            s1_alpha <= '0;
            s1_mode  <= MODE_COLOR;
        end else if (adv) begin
            s1_vld <= in_valid;
            s1_sof <= in_valid && in_sof;
            if (in_valid) begin
                s1_edge  <= edge_pix;
                s1_color <= color_pix;
                s1_sum   <= in_sum;
                s1_thr   <= cfg_thr;
                s1_alpha <= cfg_alpha;
                s1_mode  <= cfg_mode;
            end
        end
    end

    logic [PIX_W-1:0] blend_pix, s1_fused;
    logic             s1_hit;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fuser_blend_ch #(.CH_W(CH_W)) u_blend (
            .edge_ch  (s1_edge[g*CH_W +: CH_W]),
            .color_ch (s1_color[g*CH_W +: CH_W]),
            .alpha    (s1_alpha),
            .blend_ch (blend_pix[g*CH_W +: CH_W])
        );
    end

    always_comb begin
        s1_hit   = s1_sum < s1_thr;
        s1_fused = s1_color;
        case (s1_mode)
            MODE_COLOR:   s1_fused = s1_color;
            MODE_OVERLAY: s1_fused = s1_hit ? OVL_COLOR : s1_color;
            MODE_BLEND:   s1_fused = blend_pix;
            MODE_EDGE:    s1_fused = s1_edge;
        endcase
    end

    logic             s2_vld, s2_sof, s2_hit, out_hit;
    logic [PIX_W-1:0] s2_pix;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_vld    <= 1'b0;
            s2_sof    <= 1'b0;
            s2_hit    <= 1'b0;
            s2_pix    <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_hit   <= 1'b0;
            fused_pix <= '0;
        end else if (adv) begin
            s2_vld    <= s1_vld;
            s2_sof    <= s1_vld && s1_sof;
            s2_hit    <= s1_hit;
            s2_pix    <= s1_fused;
            out_valid <= s2_vld;
            out_sof   <= s2_vld && s2_sof;
            out_hit   <= s2_hit;
            fused_pix <= s2_pix;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt  <= '0;
            edge_cnt <= '0;
        end else if (out_xfer) begin
            if (out_sof) begin
                pix_cnt  <= CNT_W'(1);
                edge_cnt <= CNT_W'(out_hit);
            end else begin
                if (pix_cnt != '1)
                    pix_cnt <= pix_cnt + CNT_W'(1);
                if (out_hit && edge_cnt != '1)
                    edge_cnt <= edge_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_image_fuser_pipe.sv
// Table vectors, hand sequences and a randomized scoreboard for image_fuser_pipe.
module tb_image_fuser_pipe;
    localparam int CNT_W = 20;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] edge_pix, color_pix, fused_pix;
    logic        in_valid, in_sof, in_ready, out_valid, out_sof, out_ready;
    logic [1:0]  mode;
    logic [8:0]  alpha;
    logic [9:0]  threshold;
    logic [CNT_W-1:0] pix_cnt, edge_cnt;

    always #5 clk = ~clk;

    image_fuser_pipe dut (
        .clk(clk), .reset_n(reset_n), .edge_pix(edge_pix), .color_pix(color_pix),
        .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready), .mode(mode),
        .alpha(alpha), .threshold(threshold), .fused_pix(fused_pix), .out_valid(out_valid),
        .out_sof(out_sof), .out_ready(out_ready), .pix_cnt(pix_cnt), .edge_cnt(edge_cnt)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: per-frame config, channel-sum hit test, per-mode output.
    function automatic logic [23:0] ref_fuse(input int md, input int a, input int thr,
                                             input logic [23:0] e, input logic [23:0] c,
                                             output bit hit);
        int sum = 0;
        logic [23:0] r;
        for (int k = 0; k < 3; k++) sum += int'(e[k*8 +: 8]);
        hit = sum < thr;
        r = c;
        if (md == 3) r = e;
        else if (md == 1 && hit) r = 24'h000000;
        else if (md == 2)
            for (int k = 0; k < 3; k++)
                r[k*8 +: 8] = 8'((int'(e[k*8 +: 8]) * a + int'(c[k*8 +: 8]) * (256 - a)) / 256);
        return r;
    endfunction

    typedef struct { logic [23:0] pix; bit sof; bit hit; } exp_t;
    exp_t exp_q[$];
    int sh_md, sh_a, sh_thr, m_pix, m_edge, n_out;
    bit prev_stall;
    logic [23:0] prev_pix;
    bit prev_sof;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            sh_md = 0; sh_a = 0; sh_thr = 0; m_pix = 0; m_edge = 0; prev_stall = 0;
        end else begin
            exp_t x;
            bit h;
            if (prev_stall)
                chk(out_valid && fused_pix == prev_pix && out_sof == prev_sof, "stall_hold", fused_pix, prev_pix);
            chk(in_ready == (!out_valid || out_ready), "in_ready", in_ready, !out_valid || out_ready);
            chk(pix_cnt == CNT_W'(m_pix), "pix_cnt", pix_cnt, m_pix);
            chk(edge_cnt == CNT_W'(m_edge), "edge_cnt", edge_cnt, m_edge);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_output", fused_pix, 0);
                end else begin
                    x = exp_q.pop_front();
                    chk(fused_pix == x.pix, "sb_pix", fused_pix, x.pix);
                    chk(out_sof == x.sof, "sb_sof", out_sof, x.sof);
                    if (x.sof) begin
                        m_pix = 1; m_edge = x.hit ? 1 : 0;
                    end else begin
                        if (m_pix < (1 << CNT_W) - 1) m_pix++;
                        if (x.hit && m_edge < (1 << CNT_W) - 1) m_edge++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (in_sof) begin
                    sh_md = int'(mode);
                    sh_a = (int'(alpha) > 256) ? 256 : int'(alpha);
                    sh_thr = int'(threshold);
                end
                x.pix = ref_fuse(sh_md, sh_a, sh_thr, edge_pix, color_pix, h);
                x.hit = h;
                x.sof = in_sof;
                exp_q.push_back(x);
            end
            prev_stall = out_valid && !out_ready;
            prev_pix = fused_pix;
            prev_sof = out_sof;
        end
    end

    typedef struct {
        logic [1:0] md; logic [8:0] a; logic [9:0] thr; bit sof;
        logic [23:0] e; logic [23:0] c; logic [23:0] exp_pix; int pc; int ec;
    } vec_t;
    vec_t tbl[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] sp_e[10];
        logic [23:0] sp_c[10];
        int idx, base;
        bit acc;

        reset_n = 0; in_valid = 0; in_sof = 0; edge_pix = 0; color_pix = 0;
        mode = 0; alpha = 0; threshold = 0; out_ready = 1;

        tbl[0]  = '{2'd1, 9'd0,   10'h001, 1'b1, 24'h000000, 24'hFF0000, 24'h000000, 1, 1};
        tbl[1]  = '{2'd1, 9'd0,   10'h001, 1'b0, 24'hFFFFFF, 24'hFF0000, 24'hFF0000, 2, 1};
        tbl[2]  = '{2'd2, 9'd128, 10'h000, 1'b1, 24'hFFFFFF, 24'h000000, 24'h7F7F7F, 1, 0};
        tbl[3]  = '{2'd2, 9'd256, 10'h000, 1'b1, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 1, 0};
        tbl[4]  = '{2'd2, 9'd300, 10'h000, 1'b1, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 1, 0};
        tbl[5]  = '{2'd2, 9'd0,   10'h000, 1'b1, 24'h123456, 24'hABCDEF, 24'hABCDEF, 1, 0};
        tbl[6]  = '{2'd0, 9'd0,   10'h300, 1'b1, 24'h102030, 24'h405060, 24'h405060, 1, 1};
        tbl[7]  = '{2'd3, 9'd0,   10'h000, 1'b0, 24'h111111, 24'h222222, 24'h222222, 2, 2};
        tbl[8]  = '{2'd3, 9'd0,   10'h031, 1'b1, 24'h101010, 24'h222222, 24'h101010, 1, 1};
        tbl[9]  = '{2'd3, 9'd0,   10'h031, 1'b0, 24'h111111, 24'h222222, 24'h111111, 2, 1};
        tbl[10] = '{2'd1, 9'd0,   10'h031, 1'b1, 24'h101010, 24'h222222, 24'h000000, 1, 1};
        tbl[11] = '{2'd2, 9'd64,  10'h000, 1'b1, 24'h808080, 24'h404040, 24'h505050, 1, 0};

        #12;
        chk(out_valid == 0, "rst_out_valid", out_valid, 0);
        chk(in_ready == 1, "rst_in_ready", in_ready, 1);
        chk(fused_pix == 0, "rst_fused_pix", fused_pix, 0);
        chk(pix_cnt == 0 && edge_cnt == 0, "rst_counters", pix_cnt, 0);
        @(posedge clk); #1 reset_n = 1;
        repeat (2) tick();

        for (int i = 0; i < 12; i++) begin
            mode = tbl[i].md; alpha = tbl[i].a; threshold = tbl[i].thr; in_sof = tbl[i].sof;
            edge_pix = tbl[i].e; color_pix = tbl[i].c; in_valid = 1;
            tick();
            in_valid = 0; in_sof = 0;
            tick();
            chk(out_valid == 0, "lat_early", out_valid, 0);
            tick();
            chk(out_valid == 1, "lat_3", out_valid, 1);
            chk(fused_pix == tbl[i].exp_pix, $sformatf("vec%0d_pix", i), fused_pix, tbl[i].exp_pix);
            chk(out_sof == tbl[i].sof, $sformatf("vec%0d_sof", i), out_sof, tbl[i].sof);
            tick();
            chk(pix_cnt == CNT_W'(tbl[i].pc), $sformatf("vec%0d_pix_cnt", i), pix_cnt, tbl[i].pc);
            chk(edge_cnt == CNT_W'(tbl[i].ec), $sformatf("vec%0d_edge_cnt", i), edge_cnt, tbl[i].ec);
        end

        // 10-pixel stream with downstream stalled for cycles 4..7
        for (int k = 0; k < 10; k++) begin
            sp_e[k] = 24'($urandom);
            sp_c[k] = 24'($urandom);
        end
        mode = 2; alpha = 9'd100; threshold = 10'h200;
        idx = 0; base = n_out;
        for (int cyc = 0; cyc < 60 && idx < 10; cyc++) begin
            in_valid = 1; in_sof = (idx == 0);
            edge_pix = sp_e[idx]; color_pix = sp_c[idx];
            out_ready = !(cyc >= 4 && cyc <= 7);
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 0; in_sof = 0; out_ready = 1;
        repeat (6) tick();
        chk(idx == 10, "stall_accepted", idx, 10);
        chk(n_out - base == 10, "stall_emitted", n_out - base, 10);
        chk(pix_cnt == 10, "stall_pix_cnt", pix_cnt, 10);

        // Reset with three pixels in flight
        mode = 1; threshold = 10'h100; in_valid = 1;
        for (int k = 0; k < 3; k++) begin
            in_sof = (k == 0); edge_pix = 24'($urandom); color_pix = 24'($urandom);
            tick();
        end
        reset_n = 0; in_valid = 0; in_sof = 0;
        #1;
        chk(out_valid == 0, "midrst_out_valid", out_valid, 0);
        chk(in_ready == 1, "midrst_in_ready", in_ready, 1);
        chk(pix_cnt == 0, "midrst_pix_cnt", pix_cnt, 0);
        tick();
        reset_n = 1;
        base = n_out;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk(out_valid == 0, "post_rst_quiet", out_valid, 0);
        end
        chk(n_out == base, "post_rst_no_output", n_out, base);
        mode = 3; in_sof = 0; edge_pix = 24'h111111; color_pix = 24'h222222; in_valid = 1;
        tick();
        in_valid = 0;
        tick(); tick();
        chk(out_valid && fused_pix == 24'h222222, "post_rst_color_pass", fused_pix, 24'h222222);
        repeat (2) tick();

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sof = ($urandom_range(0, 12) == 0);
            edge_pix = 24'($urandom); color_pix = 24'($urandom);
            mode = 2'($urandom_range(0, 3));
            alpha = 9'($urandom_range(0, 400));
            threshold = 10'($urandom_range(0, 800));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 0; in_sof = 0; out_ready = 1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/image_fuser_pipe.md
IMAGE_FUSER_PIPE -- requirements
Module: image_fuser_pipe

Interface
REQ-001 Parameter CH_W, default 8: bits per colour channel.
REQ-002 Parameter NUM_CH, default 3: channels per pixel; PIX_W = CH_W*NUM_CH; SUM_W = CH_W+$clog2(NUM_CH).
REQ-003 Parameter CNT_W, default 20: width of the per-frame pixel and edge counters.
REQ-004 Parameter OVL_COLOR, default 0 (PIX_W bits): pixel substituted on edge hits in overlay mode.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 edge_pix  in  PIX_W  edge-detector pixel; channel 0 in the LSBs.
REQ-008 color_pix  in  PIX_W  colour-reduced pixel, aligned with edge_pix.
REQ-009 in_valid, in_sof  in  1 each  input pixel valid; first pixel of frame.
REQ-010 in_ready  out  1  block accepts the input pixel this cycle.
REQ-011 mode  in  2  0 colour pass, 1 edge overlay, 2 alpha blend, 3 edge pass.
REQ-012 alpha  in  CH_W+1  blend weight of edge_pix, 0..2^CH_W; larger values are clamped to 2^CH_W.
REQ-013 threshold  in  SUM_W  edge hit when the channel sum of edge_pix < threshold.
REQ-014 fused_pix, out_valid, out_sof  out  PIX_W,1,1  fused pixel with its valid and start-of-frame flags.
REQ-015 out_ready  in  1  downstream accepts fused_pix.
REQ-016 pix_cnt, edge_cnt  out  CNT_W each  pixels and edge hits emitted in the current frame.

Function
REQ-017 A transfer occurs on a cycle with valid and ready both high, on each side.
REQ-018 The datapath is a 3-stage pipeline: S1 channel sum and register of inputs, S2 compare and multiply, S3 output register.
REQ-019 Latency is exactly 3 cycles from input transfer to out_valid when out_ready is held high.
REQ-020 Pipeline enable: adv = !out_valid || out_ready; in_ready = adv; all stages shift only when adv is high.
REQ-021 Each stage carries a valid bit, so bubbles propagate; holding in_valid high with out_ready high sustains 1 pixel/cycle.
REQ-022 While out_ready is low and out_valid is high, fused_pix, out_sof and out_valid hold stable and no input is accepted.
REQ-023 mode, alpha and threshold are sampled into shadow registers only on an input transfer with in_sof=1; these values apply to that whole frame.
REQ-024 Before the first sof after reset, the shadow registers are mode=0, alpha=0, threshold=0.
REQ-025 Mode 0: fused_pix = color_pix.
REQ-026 Mode 3: fused_pix = edge_pix.
REQ-027 Mode 1: fused_pix = OVL_COLOR on an edge hit; otherwise fused_pix = color_pix.
REQ-028 Mode 2, per channel: out = (e*a + c*(2^CH_W - a)) >> CH_W, with a 2*CH_W+1-bit intermediate and truncation; a=0 yields c exactly and a=2^CH_W yields e exactly.
REQ-029 Edge hit uses an unsigned compare, sum < threshold; threshold=0 never hits.
REQ-030 Edge hits are evaluated in every mode, for edge_cnt.
REQ-031 On an output transfer with out_sof=1: pix_cnt is loaded with 1 and edge_cnt with hit?1:0.
REQ-032 On any other output transfer, pix_cnt increments and edge_cnt increments on a hit; both saturate at all-ones and never wrap.
REQ-033 in_sof arriving mid-frame starts a new frame at that pixel: shadow registers reload and counters restart when it emerges.

Reset
REQ-034 While reset_n is low, the following clear asynchronously: all stage valid bits, out_valid, out_sof, fused_pix, pix_cnt, edge_cnt and the shadow registers.
REQ-035 in_ready is 1 during and after reset, since the pipeline is empty.
REQ-036 Reset asserted mid-frame discards all in-flight pixels; no partial output follows release.
REQ-037 Deassertion is used as-is; synchronising the release of reset_n is the top level's responsibility.

Structure
REQ-038 A shared package holds the mode encodings (MODE_COLOR, MODE_OVERLAY, MODE_BLEND, MODE_EDGE) and the PIX_W/SUM_W derivations.
REQ-039 One sub-module, fuser_blend_ch, implements the single-channel blend of REQ-028.
REQ-040 fuser_blend_ch is instantiated NUM_CH times by generate.

Verification
REQ-041 Mode 1, threshold=1, edge_pix=0x000000, color_pix=0xFF0000, sof, out_ready=1 -> fused_pix=0x000000 three cycles later; edge_cnt=1, pix_cnt=1.
REQ-042 Mode 1, edge_pix=0xFFFFFF, color_pix=0xFF0000 -> fused_pix=0xFF0000; edge_cnt unchanged.
REQ-043 Mode 2, alpha=128, edge_pix=0xFFFFFF, color_pix=0x000000 -> 0x7F7F7F; alpha=256 -> 0xFFFFFF; alpha=300 -> 0xFFFFFF.
REQ-044 Stream of 10 pixels with out_ready low for cycles 4-7 -> all 10 pixels emitted in order, none lost or duplicated, fused_pix stable while stalled; pix_cnt=10.
REQ-045 Change mode from 0 to 3 mid-frame without sof -> output stays colour pass until the next sof pixel, then edge pass from that pixel.
REQ-046 Assert reset_n low with 3 pixels in flight -> out_valid=0 immediately; no output after release until new input.
